dca: RTL and testbench
======================

DCA -- requirements
Module: dca

Interface
REQ-001 SHALL have parameters: N_SECTORS=2 (sets); N_LINES=4 (ways per set); N_ELEMENTS=4 (words per line); N_BYTES=4 (bytes per word); PA_WIDTH=32; ID_WIDTH=4.
REQ-002 SHALL derive ELEMENT_WIDTH=8*N_BYTES and LINE_WIDTH=N_ELEMENTS*ELEMENT_WIDTH.
REQ-003 SHALL use one clock, and reset SHALL be synchronous and active-high. Ports: clk in 1; rst in 1.
REQ-004 SHALL have these ports:
- rnd in clog2(N_LINES): victim way for the next miss.
- i_hit in 1: translation valid for i_pa.
- i_load in mem_data_t (cache_pkg): fields enable, address, size (SIZE_BYTE/SIZE_HALF/SIZE_WORD), data.
- i_store in mem_data_t: same fields; data is the store value.
- i_pa in PA_WIDTH: physical address of the access.
- o_hit out 1; o_stall out 1; o_read_data out ELEMENT_WIDTH.
- o_mem_enable out 1: single-cycle request pulse.
- o_mem_addr out PA_WIDTH: line-aligned address.
- o_mem_data out LINE_WIDTH: writeback line.
- o_mem_type out 1: 0=read, 1=write.
- o_mem_ack out 1: response consumed.
- i_mem_enable in 1: response valid.
- i_mem_data in LINE_WIDTH.
- i_mem_id_request in ID_WIDTH: ID the memory assigns to the request issued this cycle.
- i_mem_id_response in ID_WIDTH: ID of the current response.

Function
REQ-005 SHALL split i_pa, from LSB up, into: byte offset (clog2 N_BYTES), element index (clog2 N_ELEMENTS), set index (clog2 N_SECTORS), tag (remaining bits).
REQ-006 SHALL store per way: valid, dirty, tag, line. Organisation is set-associative, write-back, write-allocate.
REQ-007 An access is active when i_hit=1 and (i_load.enable or i_store.enable). If both enables are set, load SHALL take priority and the store SHALL be ignored.
REQ-008 Hit (valid way with matching tag in the indexed set, FSM IDLE):
- o_hit=1 combinationally in the same cycle.
- o_stall=0.
REQ-009 Load hit: o_read_data SHALL be the selected element shifted right by byte offset*8 and zero-extended to size (byte 8b, half 16b, word 32b).
REQ-010 Store hit: on the next posedge, write only the size-selected bytes of i_store.data at the byte offset, and set dirty.
REQ-011 When no access is active, o_hit=0, o_stall=0 and o_read_data=0.
REQ-012 Miss SHALL assert o_stall=1 and o_hit=0 combinationally, and o_stall SHALL hold until the fill completes.
REQ-013 On a miss, the victim way SHALL be a free (invalid) way if one exists (lowest index first), otherwise way rnd sampled in the miss cycle.
REQ-014 FSM states: IDLE, WRITEBACK, REQUEST, WAIT_RESP.
- IDLE -> WRITEBACK when the victim is valid and dirty.
- IDLE -> REQUEST otherwise.
- WRITEBACK -> REQUEST after one cycle.
- REQUEST -> WAIT_RESP after one cycle.
- WAIT_RESP -> IDLE on a matching response.
REQ-015 WRITEBACK: for exactly one cycle drive o_mem_enable=1, o_mem_type=1, o_mem_addr={victim tag, set, 0}, o_mem_data=victim line; then clear the victim's dirty bit. No response is awaited.
REQ-016 REQUEST: for exactly one cycle drive o_mem_enable=1, o_mem_type=0, o_mem_addr=i_pa with offset and element bits zeroed; latch i_mem_id_request in that cycle.
REQ-017 WAIT_RESP: when i_mem_enable=1 and i_mem_id_response equals the latched ID:
- write i_mem_data into the victim way, set valid=1, dirty=0, tag=request tag;
- pulse o_mem_ack=1 for that cycle;
- go to IDLE.
Non-matching responses SHALL be ignored (no ack).
REQ-018 After the fill, the still-presented access SHALL hit on the following cycle, and a store SHALL then be written per REQ-010.
REQ-019 Outside the state cycles defined in REQ-015 to REQ-017, o_mem_enable=0, o_mem_ack=0 and o_mem_type=0.
REQ-020 Inputs may change during a stall. The miss SHALL complete for the address latched at the miss, and the hit is then re-evaluated against the current inputs.

Reset
REQ-021 While rst=1 at posedge:
- clear all valid and dirty bits;
- FSM to IDLE;
- clear the latched ID.
REQ-022 During and after reset, with no access active, all outputs SHALL be 0. Line data SHALL NOT be reset.
REQ-023 Reset asserted mid-miss SHALL abort the transaction, with no ack and no fill.

Verification
REQ-024 Cold load, pa 0x0, word; memory returns line 0x...DEADBEEF after 5 cycles with ID 1:
- o_stall=1;
- one read pulse with addr 0x0, type 0;
- o_mem_ack on the response;
- next cycle o_hit=1, o_read_data=0xDEADBEEF.
REQ-025 Store hit, pa 0x0, data 0xAABBCCDD, word: o_hit=1 with no mem request; a subsequent load of 0x0 returns 0xAABBCCDD.
REQ-026 Byte load at pa 0x1 of line word 0xDEADBEEF -> 0x000000BE; half load at pa 0x2 -> 0x0000DEAD.
REQ-027 Fill all 4 ways of set 0 and dirty way rnd=2, then miss to a new tag in set 0:
- write pulse (type 1) with way 2's address and line;
- then a read pulse;
- the fill replaces way 2.
REQ-028 A response with the wrong ID SHALL be ignored (stall held, no ack); the later matching response completes the fill.
REQ-029 i_hit=0 with load enabled -> o_hit=0, o_stall=0, no mem request.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared memory-access descriptor used by the data cache and its clients.
package cache_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic        enable;
        logic [31:0] address;
        mem_size_t   size;
        logic [31:0] data;
    } mem_data_t;

endpackage

// File: rtl/dca.sv
// Set-associative, write-back, write-allocate data cache with a single outstanding line fill.
module dca
    import cache_pkg::*;
#(
    parameter int N_SECTORS  = 2,
    parameter int N_LINES    = 4,
    parameter int N_ELEMENTS = 4,
    parameter int N_BYTES    = 4,
    parameter int PA_WIDTH   = 32,
    parameter int ID_WIDTH   = 4,
    localparam int ELEMENT_WIDTH = 8 * N_BYTES,
    localparam int LINE_WIDTH    = N_ELEMENTS * ELEMENT_WIDTH,
    localparam int WAY_W         = $clog2(N_LINES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WAY_W-1:0]         rnd,
    input  logic                     i_hit,
    input  mem_data_t                i_load,
    input  mem_data_t                i_store,
    input  logic [PA_WIDTH-1:0]      i_pa,
    output logic                     o_hit,
    output logic                     o_stall,
    output logic [ELEMENT_WIDTH-1:0] o_read_data,
    output logic                     o_mem_enable,
    output logic [PA_WIDTH-1:0]      o_mem_addr,
    output logic [LINE_WIDTH-1:0]    o_mem_data,
    output logic                     o_mem_type,
    output logic                     o_mem_ack,
    input  logic                     i_mem_enable,
    input  logic [LINE_WIDTH-1:0]    i_mem_data,
    input  logic [ID_WIDTH-1:0]      i_mem_id_request,
    input  logic [ID_WIDTH-1:0]      i_mem_id_response
);

    localparam int OFF_W = $clog2(N_BYTES);
    localparam int EL_W  = $clog2(N_ELEMENTS);
    localparam int SET_W = $clog2(N_SECTORS);
    localparam int LOW_W = OFF_W + EL_W;
    localparam int TAG_W = PA_WIDTH - LOW_W - SET_W;

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StWriteback = 2'd1;
    localparam logic [1:0] StRequest   = 2'd2;
    localparam logic [1:0] StWaitResp  = 2'd3;

    logic [N_LINES-1:0]    valid_q [N_SECTORS];
    logic [N_LINES-1:0]    dirty_q [N_SECTORS];
    logic [TAG_W-1:0]      tag_q   [N_SECTORS][N_LINES];
    logic [LINE_WIDTH-1:0] line_q  [N_SECTORS][N_LINES];

    logic [1:0]          state_q, cur_state;
    logic [SET_W-1:0]    miss_set_q;
    logic [TAG_W-1:0]    miss_tag_q;
    logic [WAY_W-1:0]    miss_way_q;
    logic [ID_WIDTH-1:0] id_q;

    logic [OFF_W-1:0] pa_off;
    logic [EL_W-1:0]  pa_el;
    logic [SET_W-1:0] pa_set;
    logic [TAG_W-1:0] pa_tag;

    logic               access, is_load, hit, miss, store_hit, fill;
    logic               hit_any;
    logic [WAY_W-1:0]   hit_way, victim;
    logic               free_found;
    mem_size_t          acc_size;
    logic [ELEMENT_WIDTH-1:0] cur_elem, size_mask, wr_mask, st_word, st_elem;
    logic [LINE_WIDTH-1:0]    cur_line;
    logic               unused_fields;

    assign pa_off = i_pa[OFF_W-1:0];
    assign pa_el  = i_pa[OFF_W +: EL_W];
    assign pa_set = i_pa[LOW_W +: SET_W];
    assign pa_tag = i_pa[PA_WIDTH-1 -: TAG_W];

    // Accesses carry the address on i_pa; the descriptor address and load data are not needed.
    assign unused_fields = ^{i_load.address, i_load.data, i_store.address};

    // Reset forces the visible state to idle so nothing leaks out while rst is held.
    assign cur_state = rst ? StIdle : state_q;
    assign access    = !rst && i_hit && (i_load.enable || i_store.enable);
    assign is_load   = i_load.enable;
    assign acc_size  = is_load ? i_load.size : i_store.size;

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < N_LINES; w++) begin
            if (valid_q[pa_set][w] && tag_q[pa_set][w] == pa_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest invalid way wins; only a full set falls back to the random way.
    always_comb begin
        free_found = 1'b0;
        victim     = rnd;
        for (int w = 0; w < N_LINES; w++) begin
            if (!free_found && !valid_q[pa_set][w]) begin
                free_found = 1'b1;
                victim     = WAY_W'(w);
            end
        end
    end

    assign hit       = access && cur_state == StIdle && hit_any;
    assign miss      = access && cur_state == StIdle && !hit_any;
    assign store_hit = hit && !is_load;

    always_comb begin
        case (acc_size)
            SIZE_BYTE: size_mask = ELEMENT_WIDTH'(8'hff);
            SIZE_HALF: size_mask = ELEMENT_WIDTH'(16'hffff);
            default:   size_mask = '1;
        endcase
    end

    assign cur_line = line_q[pa_set][hit_way];
    assign cur_elem = cur_line[int'(pa_el) * ELEMENT_WIDTH +: ELEMENT_WIDTH];
    assign st_word  = ELEMENT_WIDTH'(i_store.data);
    assign wr_mask  = size_mask << {pa_off, 3'b000};
    assign st_elem  = (cur_elem & ~wr_mask) | ((st_word << {pa_off, 3'b000}) & wr_mask);

    assign o_hit       = hit;
    assign o_stall     = miss || cur_state != StIdle;
    assign o_read_data = (hit && is_load) ? ((cur_elem >> {pa_off, 3'b000}) & size_mask) : '0;

    assign fill         = cur_state == StWaitResp && i_mem_enable && i_mem_id_response == id_q;
    assign o_mem_ack    = fill;
    assign o_mem_enable = cur_state == StWriteback || cur_state == StRequest;
    assign o_mem_type   = cur_state == StWriteback;

    always_comb begin
        o_mem_addr = '0;
        o_mem_data = '0;
        if (cur_state == StWriteback) begin
            o_mem_addr = {tag_q[miss_set_q][miss_way_q], miss_set_q, {LOW_W{1'b0}}};
            o_mem_data = line_q[miss_set_q][miss_way_q];
        end else if (cur_state == StRequest) begin
            o_mem_addr = {miss_tag_q, miss_set_q, {LOW_W{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            id_q       <= '0;
            miss_set_q <= '0;
            miss_tag_q <= '0;
            miss_way_q <= '0;
            for (int s = 0; s < N_SECTORS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (miss) begin
                        miss_set_q <= pa_set;
                        miss_tag_q <= pa_tag;
                        miss_way_q <= victim;
                        state_q    <= (valid_q[pa_set][victim] && dirty_q[pa_set][victim])
                                      ? StWriteback : StRequest;
                    end else if (store_hit) begin
                        dirty_q[pa_set][hit_way] <= 1'b1;
                    end
                end
                StWriteback: begin
                    dirty_q[miss_set_q][miss_way_q] <= 1'b0;
                    state_q <= StRequest;
                end
                StRequest: begin
                    id_q    <= i_mem_id_request;
                    state_q <= StWaitResp;
                end
                default: begin
                    if (fill) begin
                        valid_q[miss_set_q][miss_way_q] <= 1'b1;
                        dirty_q[miss_set_q][miss_way_q] <= 1'b0;
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    // Line payload and tags are plain storage and deliberately not reset.
    always_ff @(posedge clk) begin
        if (fill) begin
            line_q[miss_set_q][miss_way_q] <= i_mem_data;
            tag_q[miss_set_q][miss_way_q]  <= miss_tag_q;
        end else if (store_hit) begin
            line_q[pa_set][hit_way][int'(pa_el) * ELEMENT_WIDTH +: ELEMENT_WIDTH] <= st_elem;
        end
    end

endmodule

// File: tb/tb_dca.sv
// Directed bench for dca: cold fills, hits of each size, stores, eviction with writeback, reset abort.
module tb_dca;
    import cache_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   rnd;
    logic         i_hit;
    mem_data_t    i_load, i_store;
    logic [31:0]  i_pa;
    logic         o_hit, o_stall;
    logic [31:0]  o_read_data;
    logic         o_mem_enable, o_mem_type, o_mem_ack;
    logic [31:0]  o_mem_addr;
    logic [127:0] o_mem_data;
    logic         i_mem_enable;
    logic [127:0] i_mem_data;
    logic [3:0]   i_mem_id_request, i_mem_id_response;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] L0 = 128'h33333333_22222222_11111111_deadbeef;
    localparam logic [127:0] L1 = 128'h1d1d1d1d_1c1c1c1c_1b1b1b1b_1a1a1a1a;
    localparam logic [127:0] L2 = 128'h2d2d2d2d_2c2c2c2c_2b2b2b2b_2a2a2a2a;
    localparam logic [127:0] L3 = 128'h3d3d3d3d_3c3c3c3c_3b3b3b3b_3a3a3a3a;
    localparam logic [127:0] L4 = 128'h4d4d4d4d_4c4c4c4c_4b4b4b4b_4a4a4a4a;
    localparam logic [127:0] L2_DIRTY = 128'h2d2d2d2d_2c2c2c2c_2b2b2b2b_12345678;

    dca dut (
        .clk               (clk),
        .rst               (rst),
        .rnd               (rnd),
        .i_hit             (i_hit),
        .i_load            (i_load),
        .i_store           (i_store),
        .i_pa              (i_pa),
        .o_hit             (o_hit),
        .o_stall           (o_stall),
        .o_read_data       (o_read_data),
        .o_mem_enable      (o_mem_enable),
        .o_mem_addr        (o_mem_addr),
        .o_mem_data        (o_mem_data),
        .o_mem_type        (o_mem_type),
        .o_mem_ack         (o_mem_ack),
        .i_mem_enable      (i_mem_enable),
        .i_mem_data        (i_mem_data),
        .i_mem_id_request  (i_mem_id_request),
        .i_mem_id_response (i_mem_id_response)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic hit, input logic ld, input logic st, input logic [31:0] pa,
                         input mem_size_t sz, input logic [31:0] data);
        i_hit           = hit;
        i_pa            = pa;
        i_load.enable   = ld;
        i_load.address  = pa;
        i_load.size     = sz;
        i_load.data     = 32'h0;
        i_store.enable  = st;
        i_store.address = pa;
        i_store.size    = sz;
        i_store.data    = data;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_hit"}, o_hit, 1'b0);
        check({tag, "_stall"}, o_stall, 1'b0);
        check({tag, "_rdata"}, o_read_data, 32'h0);
        check({tag, "_men"}, o_mem_enable, 1'b0);
        check({tag, "_mtype"}, o_mem_type, 1'b0);
        check({tag, "_mack"}, o_mem_ack, 1'b0);
        check({tag, "_maddr"}, o_mem_addr, 32'h0);
        check({tag, "_mdata"}, o_mem_data, 128'h0);
    endtask

    task automatic load_hit(input string tag, input logic [31:0] pa, input mem_size_t sz,
                            input logic [31:0] exp);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, pa, sz, 32'h0);
        #1;
        check({tag, "_hit"}, o_hit, 1'b1);
        check({tag, "_stall"}, o_stall, 1'b0);
        check({tag, "_data"}, o_read_data, exp);
    endtask

    task automatic store_hit(input string tag, input logic [31:0] pa, input mem_size_t sz,
                             input logic [31:0] data);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, pa, sz, data);
        #1;
        check({tag, "_hit"}, o_hit, 1'b1);
        check({tag, "_stall"}, o_stall, 1'b0);
        check({tag, "_men"}, o_mem_enable, 1'b0);
    endtask

    // Entered in the miss cycle with the access applied; returns in the first post-fill cycle.
    task automatic run_miss(input string tag, input logic [31:0] rd_addr, input logic [127:0] line,
                            input logic [3:0] id, input bit wb, input logic [31:0] wb_addr,
                            input logic [127:0] wb_line, input int delay, input bit bad_id);
        check({tag, "_mstall"}, o_stall, 1'b1);
        check({tag, "_mhit"}, o_hit, 1'b0);
        check({tag, "_mnoreq"}, o_mem_enable, 1'b0);
        i_mem_id_request = id;
        @(negedge clk); #1;
        if (wb) begin
            check({tag, "_wben"}, o_mem_enable, 1'b1);
            check({tag, "_wbtype"}, o_mem_type, 1'b1);
            check({tag, "_wbaddr"}, o_mem_addr, wb_addr);
            check({tag, "_wbdata"}, o_mem_data, wb_line);
            @(negedge clk); #1;
        end
        check({tag, "_rden"}, o_mem_enable, 1'b1);
        check({tag, "_rdtype"}, o_mem_type, 1'b0);
        check({tag, "_rdaddr"}, o_mem_addr, rd_addr);
        check({tag, "_rdstall"}, o_stall, 1'b1);
        for (int c = 0; c < delay; c++) begin
            @(negedge clk);
            i_mem_id_request = ~id;
            if (bad_id && c == delay - 1) begin
                i_mem_enable      = 1'b1;
                i_mem_id_response = id ^ 4'h1;
                i_mem_data        = '1;
            end
            #1;
            check({tag, "_wstall"}, o_stall, 1'b1);
            check({tag, "_wen"}, o_mem_enable, 1'b0);
            check({tag, "_wack"}, o_mem_ack, 1'b0);
        end
        @(negedge clk);
        i_mem_enable      = 1'b1;
        i_mem_id_response = id;
        i_mem_data        = line;
        #1;
        check({tag, "_ack"}, o_mem_ack, 1'b1);
        check({tag, "_astall"}, o_stall, 1'b1);
        @(negedge clk);
        i_mem_enable = 1'b0;
        i_mem_data   = '0;
        #1;
        check({tag, "_fhit"}, o_hit, 1'b1);
        check({tag, "_fstall"}, o_stall, 1'b0);
        check({tag, "_fack"}, o_mem_ack, 1'b0);
    endtask

    initial begin
        rst               = 1'b1;
        rnd               = 2'd0;
        i_mem_enable      = 1'b0;
        i_mem_data        = '0;
        i_mem_id_request  = 4'h0;
        i_mem_id_response = 4'h0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, SIZE_WORD, 32'h0);

        @(negedge clk); #1;
        check_quiet("rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_quiet("post_rst");

        // Translation invalid: no access even with load enabled.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0, SIZE_WORD, 32'h0);
        #1;
        check_quiet("nohit");

        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0, SIZE_WORD, 32'h0);
        #1;
        run_miss("cold", 32'h0, L0, 4'd1, 1'b0, 32'h0, 128'h0, 5, 1'b0);
        check("cold_data", o_read_data, 32'hdeadbeef);

        load_hit("byte1", 32'h1, SIZE_BYTE, 32'h000000be);
        load_hit("half2", 32'h2, SIZE_HALF, 32'h0000dead);
        load_hit("byte3", 32'h3, SIZE_BYTE, 32'h000000de);
        load_hit("half0", 32'h0, SIZE_HALF, 32'h0000beef);
        load_hit("word4", 32'h4, SIZE_WORD, 32'h11111111);

        store_hit("st0", 32'h0, SIZE_WORD, 32'haabbccdd);
        load_hit("ld0", 32'h0, SIZE_WORD, 32'haabbccdd);
        store_hit("stb5", 32'h5, SIZE_BYTE, 32'h000000ee);
        load_hit("ld4", 32'h4, SIZE_WORD, 32'h1111ee11);

        // Both enables: load wins, store is dropped.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'h0, SIZE_WORD, 32'h0);
        #1;
        check("both_data", o_read_data, 32'haabbccdd);
        load_hit("both_after", 32'h0, SIZE_WORD, 32'haabbccdd);

        // Fill the remaining ways of set 0; the last one by a store miss.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h20, SIZE_WORD, 32'h0);
        #1;
        run_miss("w1", 32'h20, L1, 4'd2, 1'b0, 32'h0, 128'h0, 2, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h40, SIZE_WORD, 32'h0);
        #1;
        run_miss("w2", 32'h40, L2, 4'd3, 1'b0, 32'h0, 128'h0, 2, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 32'h60, SIZE_WORD, 32'hcafef00d);
        #1;
        run_miss("w3", 32'h60, L3, 4'd4, 1'b0, 32'h0, 128'h0, 1, 1'b0);
        load_hit("ld60", 32'h60, SIZE_WORD, 32'hcafef00d);

        store_hit("st40", 32'h40, SIZE_WORD, 32'h12345678);
        rnd = 2'd2;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h80, SIZE_WORD, 32'h0);
        #1;
        run_miss("evict", 32'h80, L4, 4'd5, 1'b1, 32'h40, L2_DIRTY, 3, 1'b1);
        check("evict_data", o_read_data, 32'h4a4a4a4a);
        load_hit("keep60", 32'h60, SIZE_WORD, 32'hcafef00d);
        load_hit("keep0", 32'h0, SIZE_WORD, 32'haabbccdd);
        load_hit("keep20", 32'h2c, SIZE_WORD, 32'h1d1d1d1d);

        // Way 2 was replaced, so its old tag misses; reset lands mid-transaction.
        rnd = 2'd1;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h40, SIZE_WORD, 32'h0);
        i_mem_id_request = 4'd7;
        #1;
        check("gone40_stall", o_stall, 1'b1);
        check("gone40_hit", o_hit, 1'b0);
        @(negedge clk); #1;
        check("abort_req", o_mem_enable, 1'b1);
        check("abort_type", o_mem_type, 1'b0);
        @(negedge clk); #1;
        check("abort_wait", o_mem_enable, 1'b0);
        @(negedge clk);
        rst               = 1'b1;
        i_mem_enable      = 1'b1;
        i_mem_id_response = 4'd7;
        i_mem_data        = L2;
        #1;
        check("abort_ack", o_mem_ack, 1'b0);
        check("abort_stall", o_stall, 1'b0);
        @(negedge clk);
        rst          = 1'b0;
        i_mem_enable = 1'b0;
        i_mem_data   = '0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, SIZE_WORD, 32'h0);
        #1;
        check_quiet("abort_idle");

        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'h0, SIZE_WORD, 32'h0);
        #1;
        run_miss("refill", 32'h0, L0, 4'd9, 1'b0, 32'h0, 128'h0, 1, 1'b0);
        check("refill_data", o_read_data, 32'hdeadbeef);

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, SIZE_WORD, 32'h0);
        #1;
        check_quiet("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
